// File: rtl/byte_issue_ctrl.sv
// byte_issue_ctrl: FIFO-buffered byte feeder for the load/shift/out stage,
// issuing one start pulse per PERIOD cycles and flagging each stage result with done.
module byte_issue_ctrl #(
   parameter int DEPTH  = 4,
   parameter int AW     = 2,
   parameter int PERIOD = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_in_valid,
   input  logic [7:0]    i_in_data,
   output logic          o_in_ready,
   input  logic          i_flush,
   output logic          o_start,
   output logic [7:0]    o_proc_data,
   output logic          o_done,
   output logic          o_busy,
   output logic [AW:0]   o_fifo_count
);
   localparam int PW = $clog2(PERIOD);
   typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT} state_t;
   state_t          r_state, w_next;
   logic [PW-1:0]   r_phase, w_phase_nxt;
   logic [7:0]      r_mem [DEPTH];
   logic [AW-1:0]   r_wp, r_rp;
   logic [AW:0]     r_count;
   logic            r_start, r_done, r_busy;
   logic [7:0]      r_proc_data;
   logic            w_push, w_pop, w_last;
   assign o_in_ready   = r_count != (AW+1)'(DEPTH);
   assign o_fifo_count = r_count;
   assign o_start      = r_start;
   assign o_done       = r_done;
   assign o_busy       = r_busy;
   assign o_proc_data  = r_proc_data;
   assign w_last = r_phase == PW'(PERIOD-1);
   // flush cancels both the push and any pop scheduled in the same cycle
   assign w_push = i_in_valid && o_in_ready && !i_flush;
   assign w_pop  = !i_flush && r_count != '0 && (r_state == IDLE || (r_state == WAIT && w_last));
   always_comb begin
      w_next = r_state == IDLE  ? (w_pop ? ISSUE : IDLE) :
               r_state == ISSUE ? HOLD :
               r_state == HOLD  ? WAIT :
               !w_last          ? WAIT :
               w_pop            ? ISSUE : IDLE;
      w_phase_nxt = (w_next == ISSUE || w_next == IDLE) ? '0 : r_phase + 1'b1;
   end
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= i_in_data;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp        <= '0;
         r_rp        <= '0;
         r_count     <= '0;
         r_state     <= IDLE;
         r_phase     <= '0;
         r_start     <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_proc_data <= '0;
      end else begin
         r_wp        <= i_flush ? '0 : r_wp + AW'(w_push);
         r_rp        <= i_flush ? '0 : r_rp + AW'(w_pop);
         r_count     <= i_flush ? '0 : r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
         r_state     <= w_next;
         r_phase     <= w_phase_nxt;
         r_start     <= w_pop;
         r_busy      <= w_next != IDLE;
         r_done      <= r_state == WAIT && r_phase == PW'(3);
         r_proc_data <= w_pop ? r_mem[r_rp] : r_proc_data;
      end
   end
endmodule

// File: tb/tb_byte_issue_ctrl.sv
// tb_byte_issue_ctrl: directed checks of issue timing, FIFO limits, flush and reset
// on a PERIOD=4 instance (a) and a PERIOD=6 instance (b).
module tb_byte_issue_ctrl;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   logic iv_a = 1'b0, fl_a = 1'b0, iv_b = 1'b0, fl_b = 1'b0;
   logic [7:0] id_a = '0, id_b = '0;
   logic rdy_a, st_a, dn_a, bz_a, rdy_b, st_b, dn_b, bz_b;
   logic [7:0] pd_a, pd_b;
   logic [2:0] cnt_a, cnt_b;
   byte_issue_ctrl #(.DEPTH(4), .AW(2), .PERIOD(4)) u_a (
      .clk(clk), .rst_n(rst_n), .i_in_valid(iv_a), .i_in_data(id_a), .o_in_ready(rdy_a),
      .i_flush(fl_a), .o_start(st_a), .o_proc_data(pd_a), .o_done(dn_a), .o_busy(bz_a),
      .o_fifo_count(cnt_a));
   byte_issue_ctrl #(.DEPTH(4), .AW(2), .PERIOD(6)) u_b (
      .clk(clk), .rst_n(rst_n), .i_in_valid(iv_b), .i_in_data(id_b), .o_in_ready(rdy_b),
      .i_flush(fl_b), .o_start(st_b), .o_proc_data(pd_b), .o_done(dn_b), .o_busy(bz_b),
      .o_fifo_count(cnt_b));
   int checks = 0, failures = 0;
   int ns, nd;
   int st_t [8];
   logic [7:0] st_d [8];
   int dn_t [8];
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic rec(input int k, input logic s, input logic [7:0] d, input logic dn);
      if (s && ns < 8) begin st_t[ns] = k; st_d[ns] = d; ns++; end
      if (dn && nd < 8) begin dn_t[nd] = k; nd++; end
   endtask
   initial begin
      #100000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
   initial begin
      logic gap, spur, took;
      repeat (2) tick;
      chk("rst_start", st_a, 0);
      chk("rst_proc", pd_a, 0);
      chk("rst_done", dn_a, 0);
      chk("rst_busy", bz_a, 0);
      chk("rst_count", cnt_a, 0);
      chk("rst_ready", rdy_a, 1);
      rst_n = 1'b1;
      tick;
      // single byte: pushed in cycle 0, issued in cycle 2, done in cycle 6
      iv_a = 1; id_a = 8'hA5; tick; iv_a = 0;
      chk("t1_cnt_c1", cnt_a, 1);
      chk("t1_start_c1", st_a, 0);
      tick;
      chk("t1_start_c2", st_a, 1);
      chk("t1_proc_c2", pd_a, 8'hA5);
      chk("t1_busy_c2", bz_a, 1);
      tick;
      chk("t1_start_c3", st_a, 0);
      chk("t1_proc_c3", pd_a, 8'hA5);
      tick; tick;
      chk("t1_done_c5", dn_a, 0);
      tick;
      chk("t1_done_c6", dn_a, 1);
      chk("t1_busy_c6", bz_a, 0);
      tick;
      chk("t1_done_c7", dn_a, 0);
      // burst of five into a 4-deep FIFO
      ns = 0; nd = 0;
      for (int k = 0; k < 30; k++) begin
         rec(k, st_a, pd_a, dn_a);
         if (k == 2) chk("burst_pushpop_cnt", cnt_a, 1);
         if (k == 5) begin chk("burst_full_ready", rdy_a, 0); chk("burst_full_cnt", cnt_a, 4); end
         if (k == 6) chk("burst_free_ready", rdy_a, 1);
         iv_a = k < 5; id_a = 8'(k + 1);
         tick;
      end
      iv_a = 0;
      chk("burst_nstart", ns, 5);
      chk("burst_ndone", nd, 5);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("burst_start_t%0d", i), st_t[i], 2 + 4 * i);
         chk($sformatf("burst_data%0d", i), st_d[i], i + 1);
         chk($sformatf("burst_done_t%0d", i), dn_t[i], 6 + 4 * i);
      end
      // PERIOD=6 instance with three queued bytes
      ns = 0; nd = 0; gap = 0;
      for (int k = 0; k < 25; k++) begin
         rec(k, st_b, pd_b, dn_b);
         if (k >= 2 && k <= 19 && !bz_b) gap = 1;
         if (k == 20) chk("p6_idle_busy", bz_b, 0);
         iv_b = k < 3; id_b = 8'(17 * (k + 1));
         tick;
      end
      iv_b = 0;
      chk("p6_busy_gap", gap, 0);
      chk("p6_nstart", ns, 3);
      chk("p6_ndone", nd, 3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("p6_start_t%0d", i), st_t[i], 2 + 6 * i);
         chk($sformatf("p6_data%0d", i), st_d[i], 17 * (i + 1));
         chk($sformatf("p6_done_t%0d", i), dn_t[i], 6 + 6 * i);
      end
      // flush in the ISSUE cycle of 0x10, with 0x30 pushed on the same edge
      ns = 0; nd = 0;
      for (int k = 0; k < 16; k++) begin
         rec(k, st_a, pd_a, dn_a);
         if (k == 2) chk("fl_ready_preflush", rdy_a, 1);
         if (k == 3) chk("fl_cnt", cnt_a, 0);
         iv_a = k < 3; id_a = 8'(16 * (k + 1)); fl_a = k == 2;
         tick;
      end
      iv_a = 0; fl_a = 0;
      chk("fl_nstart", ns, 1);
      chk("fl_data", st_d[0], 8'h10);
      chk("fl_start_t", st_t[0], 2);
      chk("fl_ndone", nd, 1);
      chk("fl_done_t", dn_t[0], 6);
      chk("fl_cnt_end", cnt_a, 0);
      chk("fl_proc_end", pd_a, 8'h10);
      // fill to full, then hold 0x77 until a pop frees a slot
      ns = 0; nd = 0; took = 0;
      for (int k = 0; k < 31; k++) begin
         rec(k, st_a, pd_a, dn_a);
         if (k == 5) chk("full_ready", rdy_a, 0);
         if (k == 7) chk("full_cnt_refill", cnt_a, 4);
         if (k < 5) begin iv_a = 1; id_a = 8'(8'hA1 + k); end
         else if (!took) begin iv_a = 1; id_a = 8'h77; took = rdy_a; end
         else iv_a = 0;
         tick;
      end
      iv_a = 0;
      chk("full_nstart", ns, 6);
      chk("full_ndone", nd, 6);
      chk("full_a5_before", st_d[4], 8'hA5);
      chk("full_77_last", st_d[5], 8'h77);
      chk("full_77_t", st_t[5], 22);
      // asynchronous reset during HOLD
      iv_a = 1; id_a = 8'h5A; tick; iv_a = 0;
      tick;
      chk("rh_start_c2", st_a, 1);
      tick;
      rst_n = 1'b0;
      #1;
      chk("rh_start", st_a, 0);
      chk("rh_proc", pd_a, 0);
      chk("rh_done", dn_a, 0);
      chk("rh_busy", bz_a, 0);
      chk("rh_cnt", cnt_a, 0);
      chk("rh_ready", rdy_a, 1);
      spur = 0;
      repeat (2) begin tick; if (dn_a) spur = 1; end
      rst_n = 1'b1;
      repeat (8) begin tick; if (dn_a || st_a) spur = 1; end
      chk("rh_no_done", spur, 0);
      iv_a = 1; id_a = 8'h3C; tick; iv_a = 0;
      tick;
      chk("rh_start_3c", st_a, 1);
      chk("rh_proc_3c", pd_a, 8'h3C);
      repeat (4) tick;
      chk("rh_done_3c", dn_a, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
